window_gen: RTL and testbench

- Streaming 3x3 sliding-window generator; sits directly upstream of the filter stage.
- Consumes one raster-order pixel per handshake.
- Buffers two previous image rows and emits nine window pixels (p1..p9, row-major, top-left first), matching the filter's sw_pixels1..9 inputs.
- Emits only fully interior windows: (IMG_W-2)*(IMG_H-2) windows per frame, no border padding.

---
 rtl/px_pkg.sv | 22 ++
 rtl/window_gen_line_buffer.sv | 22 ++
 rtl/window_gen.sv | 156 +++++++++++++++
 tb/tb_window_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/px_pkg.sv
// Shared pixel types, window FSM states and
// the interior-window test for the 3x3 generator.
package px_pkg;

  localparam int PX_DATA_W = 8;

  typedef logic [PX_DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_LAST
  } win_state_t;

  function automatic logic win_ok(
    input int unsigned r,
    input int unsigned c
  );
    return (r >= 2) && (c >= 2);
  endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// One-row pixel store: async read, sync write,
// same address, so a read sees the old row.
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [IMG_W];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_gen.sv
// Streaming 3x3 sliding-window generator that
// emits only fully interior windows of a frame.
module window_gen
  import px_pkg::*;
#(
  parameter int DATA_W = PX_DATA_W,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              win_ready,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_p1,
  output logic [DATA_W-1:0] win_p2,
  output logic [DATA_W-1:0] win_p3,
  output logic [DATA_W-1:0] win_p4,
  output logic [DATA_W-1:0] win_p5,
  output logic [DATA_W-1:0] win_p6,
  output logic [DATA_W-1:0] win_p7,
  output logic [DATA_W-1:0] win_p8,
  output logic [DATA_W-1:0] win_p9,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          c_last;
  logic          r_last;
  logic          px_acc;
  logic          win_acc;
  logic          fd_n;

  win_state_t state;
  win_state_t state_n;

  logic [DATA_W-1:0] lb0_q;
  logic [DATA_W-1:0] lb1_q;

  logic [DATA_W-1:0] sr  [3][3];
  logic [DATA_W-1:0] nxt [3][3];
  logic [DATA_W-1:0] wr  [3][3];

  assign c_last = (col == CW'(IMG_W - 1));
  assign r_last = (row == RW'(IMG_H - 1));

  assign in_ready = en && (!win_valid || win_ready);
  assign px_acc   = in_valid && in_ready;
  assign win_acc  = en && win_valid && win_ready;

  // lb0 holds row r-1, lb1 holds row r-2
  line_buffer #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W)
  ) lb0 (
    .clk  (clk),
    .we   (px_acc),
    .addr (col),
    .wdata(in_pixel),
    .rdata(lb0_q)
  );

  line_buffer #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W)
  ) lb1 (
    .clk  (clk),
    .we   (px_acc),
    .addr (col),
    .wdata(lb0_q),
    .rdata(lb1_q)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nxt[i][0] = sr[i][1];
      nxt[i][1] = sr[i][2];
    end
    nxt[0][2] = lb1_q;
    nxt[1][2] = lb0_q;
    nxt[2][2] = in_pixel;
  end

  always_comb begin
    state_n = state;
    fd_n    = 1'b0;
    unique case (state)
      S_FILL: begin
        if (px_acc && c_last && row == RW'(1))
          state_n = S_RUN;
      end
      S_RUN: begin
        if (px_acc && c_last && r_last)
          state_n = S_LAST;
      end
      S_LAST: begin
        if (win_acc) begin
          state_n = S_FILL;
          fd_n    = 1'b1;
        end
      end
      default: state_n = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      state      <= S_FILL;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          sr[i][j] <= '0;
          wr[i][j] <= '0;
        end
      end
    end else if (en) begin
      state      <= state_n;
      frame_done <= fd_n;
      if (px_acc) begin
        sr        <= nxt;
        win_valid <= win_ok(32'(row), 32'(col));
        if (win_ok(32'(row), 32'(col)))
          wr <= nxt;
        if (c_last) begin
          col <= '0;
          row <= r_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (win_acc) begin
        win_valid <= 1'b0;
      end
    end
  end

  assign win_p1 = wr[0][0];
  assign win_p2 = wr[0][1];
  assign win_p3 = wr[0][2];
  assign win_p4 = wr[1][0];
  assign win_p5 = wr[1][1];
  assign win_p6 = wr[1][2];
  assign win_p7 = wr[2][0];
  assign win_p8 = wr[2][1];
  assign win_p9 = wr[2][2];

endmodule

// File: tb/tb_window_gen.sv
// Randomized bench for window_gen on a 4x4 frame
// against a frame-array reference model.
module tb_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       win_ready;
  logic       win_valid;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       frame_done;

  window_gen #(
    .DATA_W(8),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .win_ready (win_ready),
    .win_valid (win_valid),
    .win_p1    (p1),
    .win_p2    (p2),
    .win_p3    (p3),
    .win_p4    (p4),
    .win_p5    (p5),
    .win_p6    (p6),
    .win_p7    (p7),
    .win_p8    (p8),
    .win_p9    (p9),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          frm [H][W];
  int          mr = 0;
  int          mc = 0;
  logic [71:0] q  [$];
  bit          ql [$];
  bit          exp_fd   = 1'b0;
  bit          acc_flag = 1'b0;
  int          wacc     = 0;
  logic [71:0] log_w [$];
  int          fd_cnt   = 0;
  logic [71:0] cur_win  = '0;
  logic [71:0] basic [4];

  wire [71:0] dut_win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  task automatic chkw(string nm, logic [71:0] act, logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(
    input int a, b, c, d, e, f, g, h, i
  );
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e),
            8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  // reference model and per-cycle compare
  always @(posedge clk) begin : mdl
    bit          pa;
    bit          wa;
    logic [71:0] w;
    if (rst) begin
      mr = 0;
      mc = 0;
      q.delete();
      ql.delete();
      exp_fd   = 1'b0;
      acc_flag = 1'b0;
    end else if (en) begin
      pa = in_valid && (q.size() == 0 || win_ready);
      wa = (q.size() != 0) && win_ready;
      acc_flag = pa;
      exp_fd   = 1'b0;
      if (wa) begin
        void'(q.pop_front());
        if (ql.pop_front()) exp_fd = 1'b1;
        log_w.push_back(cur_win);
        wacc++;
      end
      if (pa) begin
        frm[mr][mc] = int'(in_pixel);
        if (mr >= 2 && mc >= 2) begin
          w = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              w = {w[63:0], 8'(frm[mr-2+dr][mc-2+dc])};
          q.push_back(w);
          ql.push_back(mr == H-1 && mc == W-1);
        end
        if (mc == W-1) begin
          mc = 0;
          mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end else begin
      acc_flag = 1'b0;
    end
    #1;
    chk1("win_valid", win_valid, q.size() != 0);
    if (q.size() != 0) chkw("window", dut_win, q[0]);
    chk1("frame_done", frame_done, exp_fd);
    chk1("in_ready", in_ready,
         en && (q.size() == 0 || win_ready));
    cur_win = dut_win;
    if (frame_done) fd_cnt++;
  end

  // mode 0 plain, 1 backpressure, 2 bubbles and en gap
  task automatic send(int base, int n, int mode);
    int          i     = 0;
    int          guard = 0;
    int          bp    = 0;
    int          eoff  = 0;
    int          w0    = wacc;
    logic [71:0] held  = '0;
    logic        hv    = 1'b0;
    while (i < n && guard < 2000) begin
      guard++;
      in_pixel  = 8'(base + i);
      in_valid  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      win_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      en        = 1'b1;
      if (mode == 1 && wacc == w0 + 1 && q.size() != 0 && bp < 3) begin
        win_ready = 1'b0;
        bp++;
        #1;
        chk1("bp_in_ready", in_ready, 1'b0);
        chkw("bp_hold", dut_win, mk(1,2,3,5,6,7,9,10,11));
      end
      if (mode == 2 && mr == 2 && mc == 1 && eoff < 5) begin
        en = 1'b0;
        eoff++;
        if (eoff == 1) begin
          held = dut_win;
          hv   = win_valid;
        end else begin
          chkw("en_hold_win", dut_win, held);
          chk1("en_hold_valid", win_valid, hv);
        end
      end
      @(negedge clk);
      if (acc_flag) i++;
    end
    if (guard >= 2000) chk1("send_timeout", 1'b1, 1'b0);
    in_valid = 1'b0;
    en       = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    win_ready = 1'b1;
    en        = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_basic(string nm);
    chkw({nm, "_count"}, 72'(log_w.size()), 72'(4));
    for (int k = 0; k < 4; k++)
      if (k < log_w.size()) chkw(nm, log_w[k], basic[k]);
    chkw({nm, "_fd"}, 72'(fd_cnt), 72'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    basic[0] = mk(0,1,2,4,5,6,8,9,10);
    basic[1] = mk(1,2,3,5,6,7,9,10,11);
    basic[2] = mk(4,5,6,8,9,10,12,13,14);
    basic[3] = mk(5,6,7,9,10,11,13,14,15);

    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    win_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_valid", win_valid, 1'b0);
    chk1("rst_fd", frame_done, 1'b0);
    chkw("rst_win", dut_win, 72'(0));
    chk1("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    log_w.delete(); fd_cnt = 0;
    send(0, 16, 0);
    drain();
    check_basic("basic");

    log_w.delete(); fd_cnt = 0;
    send(0, 16, 1);
    drain();
    check_basic("backpressure");

    log_w.delete(); fd_cnt = 0;
    send(0, 16, 2);
    drain();
    check_basic("bubbles");

    log_w.delete(); fd_cnt = 0;
    send(0, 32, 0);
    drain();
    chkw("b2b_count", 72'(log_w.size()), 72'(8));
    if (log_w.size() == 8) begin
      chkw("b2b_first2", log_w[4], mk(16,17,18,20,21,22,24,25,26));
      chkw("b2b_last2", log_w[7], mk(21,22,23,25,26,27,29,30,31));
      chkw("b2b_last1", log_w[3], basic[3]);
    end
    chkw("b2b_fd", 72'(fd_cnt), 72'(2));

    send(0, 10, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("mrst_valid", win_valid, 1'b0);
    chk1("mrst_fd", frame_done, 1'b0);
    log_w.delete(); fd_cnt = 0;
    send(0, 16, 0);
    drain();
    check_basic("mid_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
